inst_fetcher: RTL and testbench

Consumer end of the program-counter interface. Reads the current PC and fetches the 32-bit instruction at that address over the byte-wide memory port, one byte per accepted request. Buffers completed instructions in a small FIFO for the decoder. Pulses pc_read_en to advance the PC, and handles branch flush.

---
 rtl/inst_fetcher.sv | 143 ++++++++++++++
 tb/tb_inst_fetcher.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// Instruction fetcher: assembles a 32-bit little-endian word from four byte reads
// at the current PC and queues {instruction, pc} for the decoder.
module inst_fetcher #(
    parameter int ADDR_WIDTH  = 17,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  pc_read_en,
    input  logic                  flush,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_a,
    input  logic                  mem_busy,
    input  logic [7:0]            mem_din,
    output logic                  inst_valid,
    output logic [31:0]           inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
);

    localparam int PW = $clog2(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, PUSH} state_t;

    state_t                                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]                  fetch_pc_q, fetch_pc_d;
    logic [2:0]                             issue_cnt_q, issue_cnt_d;
    logic [2:0]                             recv_cnt_q, recv_cnt_d;
    logic                                   pend_q, pend_d;
    logic [31:0]                            word_q, word_d;
    logic [QUEUE_DEPTH-1:0][31:0]           data_q, data_d;
    logic [QUEUE_DEPTH-1:0][ADDR_WIDTH-1:0] pcs_q, pcs_d;
    logic [PW-1:0]                          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                          rd_ptr_q, rd_ptr_d;
    logic [PW:0]                            cnt_q, cnt_d;

    logic accept, full, push, pop;

    assign inst_valid = (cnt_q != '0);
    assign inst_out   = data_q[rd_ptr_q];
    assign inst_pc    = pcs_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        word_d      = word_q;
        data_d      = data_q;
        pcs_d       = pcs_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;

        mem_re     = (state_q == FETCH) && (issue_cnt_q < 3'd4) && rdy_in && !flush;
        mem_a      = fetch_pc_q + ADDR_WIDTH'(issue_cnt_q);
        accept     = mem_re && !mem_busy;
        full       = (cnt_q == (PW+1)'(QUEUE_DEPTH));
        push       = (state_q == PUSH) && rdy_in && !flush;
        pop        = inst_valid && inst_ready && rdy_in && !flush;
        pc_read_en = flush || push;
        pend_d     = accept;

        if (accept)
            issue_cnt_d = issue_cnt_q + 3'd1;

        // byte capture follows the request stream, independent of rdy_in
        if (pend_q && !flush) begin
            word_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_din;
            recv_cnt_d = recv_cnt_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (rdy_in && !full) begin
                    fetch_pc_d  = pc_in;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    word_d      = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: if (rdy_in && recv_cnt_d == 3'd4) state_d = PUSH;
            PUSH:  if (rdy_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (push) begin
            data_d[wr_ptr_q] = word_q;
            pcs_d[wr_ptr_q]  = fetch_pc_q;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase

        // redirect discards the queue and any half-built word
        if (flush) begin
            state_d     = IDLE;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            pend_d      = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            pend_q      <= 1'b0;
            word_q      <= '0;
            data_q      <= '0;
            pcs_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            pend_q      <= pend_d;
            word_q      <= word_d;
            data_q      <= data_d;
            pcs_q       <= pcs_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: byte memory and PC models, scoreboard of expected
// {instruction, pc} pushed on each fetch completion and checked on each pop.
module tb_inst_fetcher;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rdy_in = 1'b1;
    logic          flush = 1'b0;
    logic          mem_busy = 1'b0;
    logic          inst_ready = 1'b0;
    logic [AW-1:0] pc_in, pc_start = '0, revise_pc = '0;
    logic          pc_read_en, mem_re, inst_valid;
    logic [AW-1:0] mem_a, inst_pc;
    logic [7:0]    mem_din;
    logic [31:0]   inst_out;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    logic [31+AW:0] exp_q[$];
    logic [AW-1:0]  issue_log[$];

    inst_fetcher #(.ADDR_WIDTH(AW), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .pc_in(pc_in), .pc_read_en(pc_read_en),
        .flush(flush), .mem_re(mem_re), .mem_a(mem_a), .mem_busy(mem_busy),
        .mem_din(mem_din), .inst_valid(inst_valid), .inst_out(inst_out),
        .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        case (a)
            17'd0:   return 8'h13;
            17'd1:   return 8'h05;
            17'd2:   return 8'h10;
            17'd3:   return 8'h00;
            default: return 8'(a * 7) ^ 8'(a >> 9) ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {mem_byte(a + AW'(3)), mem_byte(a + AW'(2)), mem_byte(a + AW'(1)), mem_byte(a)};
    endfunction

    // program counter and memory responder
    always @(posedge clk) begin
        if (!rst)            pc_in <= pc_start;
        else if (pc_read_en) pc_in <= flush ? revise_pc : pc_in + AW'(4);
        if (mem_re && !mem_busy) mem_din <= mem_byte(mem_a);
        else                     mem_din <= 8'hEE;
    end

    // scoreboard: pop compared before same-cycle push is recorded
    always @(negedge clk) begin
        if (rst) begin
            if (mem_re && !mem_busy) issue_log.push_back(mem_a);
            if (inst_valid && inst_ready && rdy_in && !flush) begin
                total++;
                pops++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_underflow: got inst=%h pc=%h, required nothing", inst_out, inst_pc);
                end else begin
                    logic [31+AW:0] e;
                    e = exp_q.pop_front();
                    if ({inst_out, inst_pc} !== e) begin
                        bad++;
                        $display("FAIL sb_pop: got inst=%h pc=%h, required inst=%h pc=%h",
                                 inst_out, inst_pc, e[31+AW:AW], e[AW-1:0]);
                    end
                end
            end
            if (flush)           exp_q.delete();
            else if (pc_read_en) exp_q.push_back({mem_word(pc_in), pc_in});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [AW-1:0] start);
        rst = 1'b0; rdy_in = 1'b1; flush = 1'b0; mem_busy = 1'b0; inst_ready = 1'b0;
        pc_start = start;
        cyc(); cyc();
        exp_q.delete(); issue_log.delete(); pops = 0;
        rst = 1'b1;
    endtask

    task automatic drain(input int n);
        inst_ready = 1'b1;
        for (int i = 0; i < 300 && pops < n; i++) cyc();
        total++;
        if (pops < n) begin
            bad++;
            $display("FAIL drain_timeout: got pops=%0d, required %0d", pops, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; pc_start = '0;
        cyc();
        @(negedge clk);
        total += 6;
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", inst_valid); end
        if (inst_out !== 32'h0)  begin bad++; $display("FAIL rst_inst: got %h, required 0", inst_out); end
        if (inst_pc !== '0)      begin bad++; $display("FAIL rst_pc: got %h, required 0", inst_pc); end
        if (mem_re !== 1'b0)     begin bad++; $display("FAIL rst_re: got %b, required 0", mem_re); end
        if (mem_a !== '0)        begin bad++; $display("FAIL rst_a: got %h, required 0", mem_a); end
        if (pc_read_en !== 1'b0) begin bad++; $display("FAIL rst_pcre: got %b, required 0", pc_read_en); end
        cyc();
        exp_q.delete(); issue_log.delete(); pops = 0;
        rst = 1'b1;
        cyc(); cyc(); cyc();
        // a request was accepted at the edge just passed; reset before its data lands
        rst = 1'b0;
        #2;
        total++;
        if (mem_re !== 1'b0) begin bad++; $display("FAIL rst_mid_re: got %b, required 0", mem_re); end
        rst = 1'b1;
        drain(1);
    endtask

    task automatic test_basic();
        do_reset('0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total += 3;
            if (mem_re !== (k >= 1 && k <= 4)) begin bad++; $display("FAIL basic_re[%0d]: got %b", k, mem_re); end
            if (pc_read_en !== (k == 6)) begin bad++; $display("FAIL basic_pcre[%0d]: got %b", k, pc_read_en); end
            if (inst_valid !== (k >= 7)) begin bad++; $display("FAIL basic_valid[%0d]: got %b", k, inst_valid); end
            if (k >= 1 && k <= 4) begin
                total++;
                if (mem_a !== AW'(k - 1)) begin bad++; $display("FAIL basic_a[%0d]: got %h, required %h", k, mem_a, k - 1); end
            end
            if (k == 7) begin
                total += 2;
                if (inst_out !== 32'h00100513) begin bad++; $display("FAIL basic_inst: got %h, required 00100513", inst_out); end
                if (inst_pc !== '0) begin bad++; $display("FAIL basic_ipc: got %h, required 0", inst_pc); end
            end
            cyc();
        end
    endtask

    task automatic test_fill();
        int extra;
        for (int i = 0; i < 100 && exp_q.size() < 4; i++) cyc();
        repeat (2) cyc();
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_re) extra++;
            cyc();
        end
        total += 3;
        if (exp_q.size() != 4) begin bad++; $display("FAIL fill_count: got %0d, required 4", exp_q.size()); end
        if (extra != 0) begin bad++; $display("FAIL fill_stall: got %0d requests, required 0", extra); end
        if (issue_log.size() != 16) begin bad++; $display("FAIL fill_issues: got %0d, required 16", issue_log.size()); end
        for (int i = 0; i < 16 && i < issue_log.size(); i++) begin
            total++;
            if (issue_log[i] !== AW'(i)) begin bad++; $display("FAIL fill_a[%0d]: got %h, required %h", i, issue_log[i], i); end
        end
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_re) break;
            cyc();
        end
        total++;
        if (mem_re !== 1'b1 || mem_a !== AW'(16)) begin
            bad++; $display("FAIL fill_fifth: got re=%b a=%h, required re=1 a=00010", mem_re, mem_a);
        end
        drain(5);
    endtask

    task automatic test_busy();
        do_reset(AW'('h40));
        for (int k = 0; k < 12; k++) begin
            mem_busy = (k >= 2 && k <= 4);
            @(negedge clk);
            total += 2;
            if (pc_read_en !== (k == 9)) begin bad++; $display("FAIL busy_pcre[%0d]: got %b", k, pc_read_en); end
            if (inst_valid !== (k >= 10)) begin bad++; $display("FAIL busy_valid[%0d]: got %b", k, inst_valid); end
            if (k >= 2 && k <= 5) begin
                total++;
                if (mem_re !== 1'b1 || mem_a !== AW'('h41)) begin
                    bad++; $display("FAIL busy_hold[%0d]: got re=%b a=%h, required re=1 a=00041", k, mem_re, mem_a);
                end
            end
            cyc();
        end
        mem_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (issue_log.size() <= i || issue_log[i] !== AW'('h40 + i)) begin
                bad++; $display("FAIL busy_issue[%0d]: got log size %0d, required addr %h", i, issue_log.size(), 'h40 + i);
            end
        end
        drain(1);
    endtask

    task automatic test_flush();
        do_reset('0);
        revise_pc = AW'('h100);
        for (int k = 0; k < 21; k++) begin
            flush = (k == 18);
            @(negedge clk);
            if (k == 18) begin
                total += 2;
                if (pc_read_en !== 1'b1) begin bad++; $display("FAIL flush_pcre: got %b, required 1", pc_read_en); end
                if (inst_valid !== 1'b1) begin bad++; $display("FAIL flush_prevalid: got %b, required 1", inst_valid); end
            end
            if (k == 19) begin
                total += 2;
                if (inst_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b, required 0", inst_valid); end
                if (mem_re !== 1'b0) begin bad++; $display("FAIL flush_re: got %b, required 0", mem_re); end
            end
            if (k == 20) begin
                total++;
                if (mem_re !== 1'b1 || mem_a !== AW'('h100)) begin
                    bad++; $display("FAIL flush_refetch: got re=%b a=%h, required re=1 a=00100", mem_re, mem_a);
                end
            end
            cyc();
        end
        flush = 1'b0;
        drain(1);
    endtask

    task automatic test_wrap();
        logic [AW-1:0] wexp [4];
        wexp = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
        do_reset(17'h1FFFE);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4) begin
                total++;
                if (mem_re !== 1'b1 || mem_a !== wexp[k-1]) begin
                    bad++; $display("FAIL wrap_a[%0d]: got re=%b a=%h, required %h", k, mem_re, mem_a, wexp[k-1]);
                end
            end
            cyc();
        end
        drain(1);
    endtask

    task automatic test_back_to_back();
        do_reset('0);
        for (int k = 0; k < 29; k++) begin
            inst_ready = (k == 27);
            @(negedge clk);
            if (k == 27) begin
                total++;
                if (pc_read_en !== 1'b1 || inst_valid !== 1'b1) begin
                    bad++; $display("FAIL b2b_push: got pcre=%b valid=%b, required 1 1", pc_read_en, inst_valid);
                end
            end
            if (k == 28) begin
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== AW'(4)) begin
                    bad++; $display("FAIL b2b_head: got valid=%b pc=%h, required 1 00004", inst_valid, inst_pc);
                end
            end
            cyc();
        end
        inst_ready = 1'b0;
        repeat (40) cyc();
        total++;
        if (issue_log.size() != 20) begin bad++; $display("FAIL b2b_issues: got %0d, required 20", issue_log.size()); end
        drain(5);
    endtask

    task automatic test_stall();
        do_reset(AW'('h80));
        for (int k = 0; k < 13; k++) begin
            rdy_in = !(k >= 2 && k <= 6);
            @(negedge clk);
            total++;
            if (pc_read_en !== (k == 11)) begin bad++; $display("FAIL stall_pcre[%0d]: got %b", k, pc_read_en); end
            if (k >= 2 && k <= 6) begin
                total++;
                if (mem_re !== 1'b0) begin bad++; $display("FAIL stall_re[%0d]: got %b, required 0", k, mem_re); end
            end
            if (k >= 7 && k <= 9) begin
                total++;
                if (mem_re !== 1'b1 || mem_a !== AW'('h81 + k - 7)) begin
                    bad++; $display("FAIL stall_resume[%0d]: got re=%b a=%h, required %h", k, mem_re, mem_a, 'h81 + k - 7);
                end
            end
            cyc();
        end
        rdy_in = 1'b1;
        drain(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_busy();
        test_flush();
        test_wrap();
        test_back_to_back();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
